// File: rtl/countdown_timer.sv
// Loadable down-counter on the divided clock: counts load_val down to zero,
// supports pause/resume, then blinks the LEDs for a fixed number of ticks.
module countdown_timer #(
  parameter int WIDTH        = 4,
  parameter int BLINK_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start_btn,
  input  logic             pause_btn,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             done
);

  localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [WIDTH-1:0]       count_r, count_nxt_s;
  logic [BW-1:0]          blink_cnt_r, blink_cnt_nxt_s;
  logic                   blink_phase_r, blink_phase_nxt_s;
  logic [SYNC_STAGES-1:0] start_sync_r, pause_sync_r;
  logic                   start_prev_r, pause_prev_r;
  logic                   start_evt_s, pause_evt_s;

  // Button synchronizers plus previous-value flops for rising-edge detection
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      start_sync_r <= {SYNC_STAGES{1'b0}};
      pause_sync_r <= {SYNC_STAGES{1'b0}};
      start_prev_r <= 1'b0;
      pause_prev_r <= 1'b0;
    end else begin
      start_sync_r <= {start_sync_r[SYNC_STAGES-2:0], start_btn};
      pause_sync_r <= {pause_sync_r[SYNC_STAGES-2:0], pause_btn};
      start_prev_r <= start_sync_r[SYNC_STAGES-1];
      pause_prev_r <= pause_sync_r[SYNC_STAGES-1];
    end
  end

  assign start_evt_s = start_sync_r[SYNC_STAGES-1] & ~start_prev_r;
  assign pause_evt_s = pause_sync_r[SYNC_STAGES-1] & ~pause_prev_r;

  // State, counter and blink registers
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      count_r       <= {WIDTH{1'b0}};
      blink_cnt_r   <= {BW{1'b0}};
      blink_phase_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      count_r       <= count_nxt_s;
      blink_cnt_r   <= blink_cnt_nxt_s;
      blink_phase_r <= blink_phase_nxt_s;
    end
  end

  // Next-state and next-counter decode
  always_comb begin
    state_nxt_s       = state_r;
    count_nxt_s       = count_r;
    blink_cnt_nxt_s   = blink_cnt_r;
    blink_phase_nxt_s = blink_phase_r;
    case (state_r)
      ST_IDLE: begin
        count_nxt_s = load_val;
        if (start_evt_s) begin
          if (load_val != {WIDTH{1'b0}}) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s       = ST_DONE;
            count_nxt_s       = {WIDTH{1'b0}};
            blink_cnt_nxt_s   = {BW{1'b0}};
            blink_phase_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // pause wins over a simultaneous start and suppresses this edge's decrement
        if (pause_evt_s) begin
          state_nxt_s = ST_PAUSED;
        end else if (count_r <= WIDTH'(1)) begin
          state_nxt_s       = ST_DONE;
          count_nxt_s       = {WIDTH{1'b0}};
          blink_cnt_nxt_s   = {BW{1'b0}};
          blink_phase_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_r - WIDTH'(1);
        end
      end
      ST_PAUSED: begin
        if (start_evt_s || pause_evt_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      ST_DONE: begin
        blink_phase_nxt_s = ~blink_phase_r;
        blink_cnt_nxt_s   = blink_cnt_r + BW'(1);
        // leaving DONE reloads the preview so IDLE shows load_val straight away
        if (start_evt_s || (blink_cnt_r == BLINK_LAST)) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = load_val;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s       = ST_IDLE;
        count_nxt_s       = {WIDTH{1'b0}};
        blink_cnt_nxt_s   = {BW{1'b0}};
        blink_phase_nxt_s = 1'b0;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    led     = count_r;
    running = 1'b0;
    done    = 1'b0;
    case (state_r)
      ST_RUN: begin
        running = 1'b1;
      end
      ST_DONE: begin
        led  = {WIDTH{blink_phase_r}};
        done = 1'b1;
      end
      default: begin
        led = count_r;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=4, BLINK_CYCLES=8, SYNC_STAGES=2).
module tb_countdown_timer;

  logic       div_clk;
  logic       rst;
  logic [3:0] load_val;
  logic       start_btn;
  logic       pause_btn;
  logic [3:0] led;
  logic       running;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  countdown_timer #(.WIDTH(4), .BLINK_CYCLES(8), .SYNC_STAGES(2)) dut (
    .div_clk  (div_clk),
    .rst      (rst),
    .load_val (load_val),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .led      (led),
    .running  (running),
    .done     (done)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_led, input logic e_run, input logic e_done);
    chk({tag, ".led"}, {28'd0, led}, {28'd0, e_led});
    chk({tag, ".running"}, {31'd0, running}, {31'd0, e_run});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
  endtask

  // one-edge start pulse; the event takes effect on the third edge
  task automatic pulse_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_pause();
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    tick();
    tick();
  endtask

  // from RUN showing c, reaching IDLE takes c-1 decrements, 8 DONE edges and the exit edge
  task automatic run_out(input int c, input logic [3:0] idle_val, input string tag);
    for (int i = 0; i < c + 8; i++) tick();
    chk_all(tag, idle_val, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    load_val  = 4'd3;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    #12;
    chk_all("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("idle_preview", 4'd3, 1'b0, 1'b0);

    // 1: basic countdown and blink
    pulse_start();
    chk_all("t1_run3", 4'd3, 1'b1, 1'b0);
    tick(); chk_all("t1_run2", 4'd2, 1'b1, 1'b0);
    tick(); chk_all("t1_run1", 4'd1, 1'b1, 1'b0);
    tick(); chk_all("t1_done0", 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_all("t1_blink", (i % 2 == 0) ? 4'h0 : 4'hF, 1'b0, 1'b1);
    end
    tick(); chk_all("t1_idle", 4'd3, 1'b0, 1'b0);
    tick(); chk_all("t1_idle2", 4'd3, 1'b0, 1'b0);

    // 2: pause and resume
    load_val = 4'd7;
    pulse_start();
    chk_all("t2_run7", 4'd7, 1'b1, 1'b0);
    pause_btn = 1'b1;
    tick(); pause_btn = 1'b0;
    chk_all("t2_lat1", 4'd6, 1'b1, 1'b0);
    tick(); chk_all("t2_lat2", 4'd5, 1'b1, 1'b0);
    tick(); chk_all("t2_paused", 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk_all("t2_hold", 4'd5, 1'b0, 1'b0);
    pulse_pause();
    chk_all("t2_resume", 4'd5, 1'b1, 1'b0);
    tick(); chk_all("t2_dec", 4'd4, 1'b1, 1'b0);
    run_out(4, 4'd7, "t2_end");

    // 3: zero load goes straight to DONE
    load_val = 4'd0;
    tick();
    pulse_start();
    chk_all("t3_done", 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_all("t3_blink", (i % 2 == 0) ? 4'h0 : 4'hF, 1'b0, 1'b1);
    end
    tick(); chk_all("t3_idle", 4'd0, 1'b0, 1'b0);

    // 4: simultaneous start and pause -> pause wins
    load_val = 4'd9;
    tick();
    pulse_start();
    chk_all("t4_run9", 4'd9, 1'b1, 1'b0);
    start_btn = 1'b1;
    pause_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    tick(); chk_all("t4_lat", 4'd7, 1'b1, 1'b0);
    tick(); chk_all("t4_paused", 4'd7, 1'b0, 1'b0);
    tick(); chk_all("t4_hold", 4'd7, 1'b0, 1'b0);
    pulse_start();
    chk_all("t4_resume", 4'd7, 1'b1, 1'b0);
    tick(); chk_all("t4_dec6", 4'd6, 1'b1, 1'b0);
    tick(); chk_all("t4_dec5", 4'd5, 1'b1, 1'b0);
    run_out(5, 4'd9, "t4_end");

    // 5: asynchronous reset mid-run
    load_val = 4'd6;
    pulse_start();
    tick(); chk_all("t5_run5", 4'd5, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("t5_async_rst", 4'd0, 1'b0, 1'b0);
    load_val = 4'hA;
    #1 rst = 1'b0;
    tick(); chk_all("t5_reload", 4'hA, 1'b0, 1'b0);

    // 6a: held start produces a single run
    load_val = 4'd4;
    tick();
    start_btn = 1'b1;
    tick(); tick(); tick();
    chk_all("t6_run4", 4'd4, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk_all("t6_run1", 4'd1, 1'b1, 1'b0);
    tick(); chk_all("t6_done", 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) tick();
    chk_all("t6_no_restart", 4'd4, 1'b0, 1'b0);
    start_btn = 1'b0;
    tick(); chk_all("t6_release", 4'd4, 1'b0, 1'b0);

    // 6b: start during DONE acknowledges early
    pulse_start();
    tick(); tick(); tick(); tick();
    chk_all("t6b_done", 4'hF, 1'b0, 1'b1);
    start_btn = 1'b1;
    tick(); start_btn = 1'b0;
    tick(); chk_all("t6b_still_done", 4'hF, 1'b0, 1'b1);
    tick(); chk_all("t6b_ack", 4'd4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
